// File: rtl/snoop_bus_arbiter.sv
// Shared-bus arbiter for the 4-processor MSI snooping system: round-robin grant,
// then a writeback -> snoop -> memory -> done sequence for the owner.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | bus free; pick round-robin winner from req
//   WB       | mem_wr held WB_CYCLES cycles for the owner's dirty victim
//   SNOOP    | one-cycle snoop_valid broadcast of snoop_op/snoop_src
//   MEM      | mem_rd held MEM_CYCLES cycles for the block fetch
//   DONE     | done[owner] pulse; advance rr pointer past the owner
module snoop_bus_arbiter #(
    parameter int N_PROC     = 4,
    parameter int WB_CYCLES  = 2,
    parameter int MEM_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_PROC-1:0]     req,
    input  logic [3*N_PROC-1:0]   req_op,
    input  logic [N_PROC-1:0]     req_wb,
    output logic [N_PROC-1:0]     grant,
    output logic                  snoop_valid,
    output logic [2:0]            snoop_op,
    output logic [1:0]            snoop_src,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [N_PROC-1:0]     done,
    output logic                  busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WB    = 3'd1;
    localparam logic [2:0] ST_SNOOP = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [2:0] OP_RD_MISS = 3'b001;
    localparam logic [2:0] OP_WR_MISS = 3'b010;

    logic [2:0]        state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        owner_q, owner_d;
    logic [2:0]        op_q, op_d;
    logic [N_PROC-1:0] grant_q, grant_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [2:0] ops [N_PROC];
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] probe_idx;

    always_comb begin
        for (int i = 0; i < N_PROC; i++) begin
            ops[i] = req_op[3*i +: 3];
        end
    end

    // First requester at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        probe_idx = rr_ptr_q;
        for (int k = 0; k < N_PROC; k++) begin
            probe_idx = rr_ptr_q + 2'(k);
            if (!win_found && req[probe_idx]) begin
                win_found = 1'b1;
                win_idx   = probe_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        op_d     = op_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    op_d    = ops[win_idx];
                    grant_d = N_PROC'(1) << win_idx;
                    if (req_wb[win_idx]) begin
                        state_d = ST_WB;
                        cnt_d   = 4'(WB_CYCLES - 1);
                    end else begin
                        state_d = ST_SNOOP;
                    end
                end
            end
            ST_WB: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_SNOOP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SNOOP: begin
                // Invalidates and no-op codes skip memory entirely.
                if (op_q == OP_RD_MISS || op_q == OP_WR_MISS) begin
                    state_d = ST_MEM;
                    cnt_d   = 4'(MEM_CYCLES - 1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_MEM: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                rr_ptr_d = owner_q + 2'd1;
                state_d  = ST_IDLE;
                grant_d  = '0;
                op_d     = 3'b000;
                owner_d  = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                op_d    = 3'b000;
                owner_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 2'b00;
            owner_q  <= 2'b00;
            op_q     <= 3'b000;
            grant_q  <= '0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign snoop_op    = op_q;
    assign snoop_src   = owner_q;
    assign busy        = (state_q != ST_IDLE);
    assign snoop_valid = (state_q == ST_SNOOP);
    assign mem_wr      = (state_q == ST_WB);
    assign mem_rd      = (state_q == ST_MEM);
    assign done        = (state_q == ST_DONE) ? grant_q : '0;

endmodule
